// File: rtl/a1339_angle_tracker.sv
// A1339 angle post-processing stage.
// Turns validated raw angle samples into a multi-turn absolute position, a
// zero-referenced relative position, a windowed velocity and a revolution
// count. Two pipeline stages follow the capture register: stage 1 decides the
// wrap direction, stage 2 accumulates turns and registers all angle outputs.
module a1339_angle_tracker #(
    parameter int ANGLE_BITS   = 12,
    parameter int ERR_CNT_BITS = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    angle_valid_i,
    input  logic [ANGLE_BITS-1:0]   angle_raw_i,
    input  logic                    angle_error_i,
    input  logic                    zero_offset,
    input  logic [31:0]             velocity_window_i,
    output logic signed [31:0]      sensor_angle,
    output logic signed [31:0]      sensor_angle_absolute,
    output logic signed [31:0]      sensor_angle_offset,
    output logic signed [31:0]      sensor_angle_relative,
    output logic signed [31:0]      sensor_angle_velocity,
    output logic signed [31:0]      sensor_revolution_counter,
    output logic                    cycle,
    output logic [ERR_CNT_BITS-1:0] error_count
);

    // Half a revolution, in the signed width used for the sample-to-sample delta.
    localparam logic signed [ANGLE_BITS:0] HALF_TURN = {2'b01, {(ANGLE_BITS-1){1'b0}}};

    logic accept;
    logic reject;

    // Capture register (accepting edge).
    logic                  s0_valid;
    logic [ANGLE_BITS-1:0] s0_raw;
    logic                  s0_zero;

    // Stage 1 state.
    logic                  s1_valid;
    logic [ANGLE_BITS-1:0] s1_raw;
    logic signed [1:0]     s1_dir;
    logic                  s1_zero;
    logic [ANGLE_BITS-1:0] prev_raw;
    logic                  first_sample;

    // Combinational helpers.
    logic signed [ANGLE_BITS:0] delta;
    logic signed [1:0]          dir;
    logic signed [31:0]         rev_next;
    logic signed [31:0]         abs_next;

    // Velocity window state.
    logic [31:0]        win_cnt;
    logic signed [31:0] win_snapshot;

    assign accept = angle_valid_i & ~angle_error_i;
    assign reject = angle_valid_i &  angle_error_i;

    // Wrap direction of the sample entering stage 1.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        delta = $signed({1'b0, s0_raw}) - $signed({1'b0, prev_raw});
        dir   = 2'sd0;
        if (delta > HALF_TURN) begin
            dir = -2'sd1;
        end else if (delta < -HALF_TURN) begin
            dir = 2'sd1;
        end
        if (first_sample) begin
            dir = 2'sd0;
        end
    end

    // Updated turn count and absolute position for the sample entering stage 2.
    always_comb begin
        rev_next = sensor_revolution_counter + {{30{s1_dir[1]}}, s1_dir};
        abs_next = (rev_next << ANGLE_BITS) + {{(32-ANGLE_BITS){1'b0}}, s1_raw};
    end

    // Capture accepted samples together with the zero request of that moment.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            s0_valid <= 1'b0;
            s0_raw   <= '0;
            s0_zero  <= 1'b0;
        end else begin
            s0_valid <= accept;
            s0_raw   <= angle_raw_i;
            s0_zero  <= zero_offset;
        end
    end

    // Stage 1: register the wrap direction and remember the last good raw angle.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_raw       <= '0;
            s1_dir       <= 2'sd0;
            s1_zero      <= 1'b0;
            prev_raw     <= '0;
            first_sample <= 1'b1;
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_raw       <= s0_raw;
                s1_dir       <= dir;
                s1_zero      <= s0_zero;
                prev_raw     <= s0_raw;
                first_sample <= 1'b0;
            end
        end
    end

    // Stage 2: accumulate turns and publish the angle set with a cycle strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            sensor_angle              <= '0;
            sensor_angle_absolute     <= '0;
            sensor_angle_offset       <= '0;
            sensor_angle_relative     <= '0;
            sensor_revolution_counter <= '0;
            cycle                     <= 1'b0;
        end else begin
            cycle <= s1_valid;
            if (s1_valid) begin
                sensor_angle              <= {{(32-ANGLE_BITS){1'b0}}, s1_raw};
                sensor_revolution_counter <= rev_next;
                sensor_angle_absolute     <= abs_next;
                if (s1_zero) begin
                    sensor_angle_offset   <= abs_next;
                    sensor_angle_relative <= '0;
                end else begin
                    sensor_angle_relative <= abs_next - sensor_angle_offset;
                end
            end
        end
    end

    // Velocity: absolute displacement over each completed window of clk cycles.
    // The published absolute is read, so a coinciding stage-2 update is not yet seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt               <= '0;
            win_snapshot          <= '0;
            sensor_angle_velocity <= '0;
        end else if (velocity_window_i == 32'd0) begin
            win_cnt               <= '0;
            win_snapshot          <= sensor_angle_absolute;
            sensor_angle_velocity <= '0;
        end else if (win_cnt >= velocity_window_i - 32'd1) begin
            // ">=" also closes a window whose length was just cut below the count.
            win_cnt               <= '0;
            win_snapshot          <= sensor_angle_absolute;
            sensor_angle_velocity <= sensor_angle_absolute - win_snapshot;
        end else begin
            win_cnt <= win_cnt + 32'd1;
        end
    end

    // Saturating count of frames rejected for parity/error.
    always_ff @(posedge clk) begin
        if (reset) begin
            error_count <= '0;
        end else if (reject && (error_count != {ERR_CNT_BITS{1'b1}})) begin
            error_count <= error_count + ERR_CNT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_a1339_angle_tracker.sv
// Self-checking bench for a1339_angle_tracker: directed scenarios followed by a
// randomized phase, all compared every sampled cycle against a reference model
// that unwraps each accepted sample at accept time and releases it two edges later.
module tb_a1339_angle_tracker;

    localparam int AB   = 12;
    localparam int REV  = 1 << AB;
    localparam int HALF = 1 << (AB - 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               angle_valid_i;
    logic [AB-1:0]      angle_raw_i;
    logic               angle_error_i;
    logic               zero_offset;
    logic [31:0]        velocity_window_i;
    logic signed [31:0] sensor_angle;
    logic signed [31:0] sensor_angle_absolute;
    logic signed [31:0] sensor_angle_offset;
    logic signed [31:0] sensor_angle_relative;
    logic signed [31:0] sensor_angle_velocity;
    logic signed [31:0] sensor_revolution_counter;
    logic               cycle;
    logic [15:0]        error_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    a1339_angle_tracker #(.ANGLE_BITS(AB), .ERR_CNT_BITS(16)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .angle_valid_i             (angle_valid_i),
        .angle_raw_i               (angle_raw_i),
        .angle_error_i             (angle_error_i),
        .zero_offset               (zero_offset),
        .velocity_window_i         (velocity_window_i),
        .sensor_angle              (sensor_angle),
        .sensor_angle_absolute     (sensor_angle_absolute),
        .sensor_angle_offset       (sensor_angle_offset),
        .sensor_angle_relative     (sensor_angle_relative),
        .sensor_angle_velocity     (sensor_angle_velocity),
        .sensor_revolution_counter (sensor_revolution_counter),
        .cycle                     (cycle),
        .error_count               (error_count)
    );

    // ---------------- reference model ----------------
    typedef struct {
        longint             due;
        logic signed [31:0] ang;
        logic signed [31:0] abs_pos;
        logic signed [31:0] off;
        logic signed [31:0] rel;
        logic signed [31:0] rev;
    } upd_t;

    upd_t   pend[$];
    longint edge_n = 0;

    // Expected visible outputs.
    logic signed [31:0] e_angle = 0, e_abs = 0, e_off = 0, e_rel = 0, e_vel = 0, e_rev = 0;
    logic               e_cycle = 1'b0;
    int                 e_err = 0;

    // Accept-time view of the unwrapped position.
    int                 t_prev = 0;
    bit                 t_first = 1'b1;
    logic signed [31:0] t_rev = 0;
    logic signed [31:0] t_off = 0;

    // Velocity bookkeeping: edges elapsed in the current window, position at its start.
    longint             v_elapsed = 0;
    logic signed [31:0] v_start = 0;

    always @(posedge clk) begin
        int   step;
        upd_t u;
        edge_n++;
        if (reset) begin
            pend.delete();
            e_angle = 0; e_abs = 0; e_off = 0; e_rel = 0; e_vel = 0; e_rev = 0;
            e_cycle = 1'b0; e_err = 0;
            t_prev = 0; t_first = 1'b1; t_rev = 0; t_off = 0;
            v_elapsed = 0; v_start = 0;
        end else begin
            // Window accounting sees the position published before this edge.
            if (velocity_window_i == 0) begin
                v_elapsed = 0;
                v_start   = e_abs;
                e_vel     = 0;
            end else if (v_elapsed + 1 >= longint'(velocity_window_i)) begin
                e_vel     = e_abs - v_start;
                v_start   = e_abs;
                v_elapsed = 0;
            end else begin
                v_elapsed++;
            end
            // Release the sample accepted two edges ago.
            e_cycle = 1'b0;
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                u = pend.pop_front();
                e_angle = u.ang; e_abs = u.abs_pos; e_off = u.off;
                e_rel = u.rel; e_rev = u.rev; e_cycle = 1'b1;
            end
            if (angle_valid_i && angle_error_i && e_err < 65535) e_err++;
            if (angle_valid_i && !angle_error_i) begin
                step = int'(angle_raw_i) - t_prev;
                if (!t_first) begin
                    if (step > HALF)       t_rev = t_rev - 1;
                    else if (step < -HALF) t_rev = t_rev + 1;
                end
                t_first   = 1'b0;
                t_prev    = int'(angle_raw_i);
                u.abs_pos = t_rev * REV + int'(angle_raw_i);
                if (zero_offset) t_off = u.abs_pos;
                u.due = edge_n + 2;
                u.ang = int'(angle_raw_i);
                u.off = t_off;
                u.rel = u.abs_pos - t_off;
                u.rev = t_rev;
                pend.push_back(u);
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".angle"}, sensor_angle, e_angle);
        chk({tag, ".abs"},   sensor_angle_absolute, e_abs);
        chk({tag, ".off"},   sensor_angle_offset, e_off);
        chk({tag, ".rel"},   sensor_angle_relative, e_rel);
        chk({tag, ".vel"},   sensor_angle_velocity, e_vel);
        chk({tag, ".rev"},   sensor_revolution_counter, e_rev);
        chk({tag, ".cycle"}, 32'(cycle), 32'(e_cycle));
        chk({tag, ".err"},   32'(error_count), 32'(e_err));
    endtask

    // Advance n edges, comparing against the model at each following negedge.
    task automatic run(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            check_all(tag);
        end
    endtask

    // Present one valid frame for a single edge.
    task automatic send(input int raw, input bit zero, input bit err, input string tag);
        angle_valid_i = 1'b1;
        angle_raw_i   = AB'(raw);
        zero_offset   = zero;
        angle_error_i = err;
        @(negedge clk);
        angle_valid_i = 1'b0;
        angle_error_i = 1'b0;
        zero_offset   = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input int window);
        reset             = 1'b1;
        velocity_window_i = 32'(window);
        run(2, "rst");
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; angle_valid_i = 1'b0; angle_raw_i = '0;
        angle_error_i = 1'b0; zero_offset = 1'b0; velocity_window_i = 0;
        @(negedge clk);
        do_reset(0);
        chk("reset.abs", sensor_angle_absolute, 0);
        chk("reset.cycle", 32'(cycle), 0);

        // Basic: pulse exactly two edges after the accepting edge.
        send(100, 0, 0, "basic");
        chk("basic.lat0", 32'(cycle), 0);
        run(1, "basic");
        chk("basic.lat1", 32'(cycle), 0);
        run(1, "basic");
        chk("basic.lat2", 32'(cycle), 1);
        send(200, 0, 0, "basic");
        run(2, "basic");
        chk("basic.angle", sensor_angle, 200);
        chk("basic.abs", sensor_angle_absolute, 200);
        chk("basic.rev", sensor_revolution_counter, 0);
        chk("basic.rel", sensor_angle_relative, 200);

        // Forward wrap, then an exact half-turn step that must not count.
        do_reset(0);
        send(4000, 0, 0, "fwd");
        send(50, 0, 0, "fwd");
        run(2, "fwd");
        chk("fwd.rev", sensor_revolution_counter, 1);
        chk("fwd.abs", sensor_angle_absolute, 4146);
        send(0, 0, 0, "half");
        send(2048, 0, 0, "half");
        run(2, "half");
        chk("half.rev", sensor_revolution_counter, 1);
        chk("half.abs", sensor_angle_absolute, 6144);

        // Offset capture at rev 1.
        send(1000, 1, 0, "off");
        run(2, "off");
        chk("off.off", sensor_angle_offset, 5096);
        chk("off.rel", sensor_angle_relative, 0);
        send(1010, 0, 0, "off");
        run(2, "off");
        chk("off.rel2", sensor_angle_relative, 10);
        chk("off.off2", sensor_angle_offset, 5096);

        // Backward wrap.
        do_reset(0);
        send(50, 0, 0, "bwd");
        send(4000, 0, 0, "bwd");
        run(2, "bwd");
        chk("bwd.rev", sensor_revolution_counter, -1);
        chk("bwd.abs", sensor_angle_absolute, -96);
        chk("bwd.angle", sensor_angle, 4000);

        // Error frames.
        do_reset(0);
        send(100, 0, 0, "err");
        run(2, "err");
        send(3000, 0, 1, "err");
        run(3, "err");
        chk("err.cnt", 32'(error_count), 1);
        chk("err.angle", sensor_angle, 100);
        send(110, 0, 0, "err");
        run(2, "err");
        chk("err.abs", sensor_angle_absolute, 110);
        chk("err.rev", sensor_revolution_counter, 0);
        angle_valid_i = 1'b1; angle_error_i = 1'b1; angle_raw_i = AB'(7);
        repeat (65536) @(negedge clk);
        angle_valid_i = 1'b0; angle_error_i = 1'b0;
        run(2, "errsat");
        chk("errsat.cnt", 32'(error_count), 65535);

        // Velocity over a 1000-cycle window; window ends on the 1000th edge after reset.
        do_reset(1000);
        send(500, 0, 0, "vel");
        run(998, "vel");
        chk("vel.before", sensor_angle_velocity, 0);
        run(1, "vel");
        chk("vel.win", sensor_angle_velocity, 500);
        run(1000, "vel");
        chk("vel.idle", sensor_angle_velocity, 0);
        send(900, 0, 0, "vel");
        velocity_window_i = 0;
        run(20, "vel0");
        chk("vel.off", sensor_angle_velocity, 0);

        // Back-to-back valids.
        do_reset(0);
        angle_valid_i = 1'b1; angle_raw_i = AB'(4000);
        @(negedge clk); check_all("b2b");
        angle_raw_i = AB'(50);
        @(negedge clk); check_all("b2b");
        angle_valid_i = 1'b0;
        run(1, "b2b");
        chk("b2b.c1", 32'(cycle), 1);
        chk("b2b.rev1", sensor_revolution_counter, 0);
        run(1, "b2b");
        chk("b2b.c2", 32'(cycle), 1);
        chk("b2b.rev2", sensor_revolution_counter, 1);

        // Reset while a sample is in flight: no pulse for it.
        send(1234, 0, 0, "flush");
        reset = 1'b1;
        run(1, "flush");
        reset = 1'b0;
        run(1, "flush");
        chk("flush.cycle", 32'(cycle), 0);
        run(3, "flush");

        // Randomized traffic with short, changing velocity windows.
        velocity_window_i = 5;
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(99) == 0);
            angle_valid_i = $urandom_range(1);
            angle_error_i = ($urandom_range(6) == 0);
            zero_offset   = ($urandom_range(9) == 0);
            angle_raw_i   = AB'($urandom);
            if ($urandom_range(19) == 0) velocity_window_i = $urandom_range(8);
            @(negedge clk);
            check_all("rand");
        end
        angle_valid_i = 1'b0; reset = 1'b0;
        run(4, "tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
